// File: rtl/wired0_defines.sv
// Shared type and constant definitions for the WIRED backend.
// Holds the issue-queue -> MDU request/response structs, the MDU op codes,
// the MDU FSM state type and small arithmetic helpers used by the MDU.
package wired0_defines;

    typedef logic [5:0] rob_rid_t;

    localparam logic [1:0] MDU_MUL  = 2'b00;
    localparam logic [1:0] MDU_MULH = 2'b01;
    localparam logic [1:0] MDU_DIV  = 2'b10;
    localparam logic [1:0] MDU_MOD  = 2'b11;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] r0;
        logic [31:0] r1;
        rob_rid_t    wid;
    } iq_mdu_req_t;

    typedef struct packed {
        rob_rid_t    wid;
        logic [31:0] result;
    } iq_mdu_resp_t;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StDone
    } mdu_state_e;

    // Magnitude of a two's complement value; INT_MIN maps to 0x80000000,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    // Operand pairs whose divide result is fixed and needs no iteration.
    function automatic logic div_special(input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    endfunction

endpackage

// File: rtl/wired_mdu_div.sv
// Radix-2 restoring unsigned divider, one quotient bit per cycle.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start_i           - load operands; iterations run in the following 32 cycles
//   kill_i            - abandon the current division
//   dividend_i/divisor_i - unsigned operands, sampled on start_i
//   busy_o            - an iteration happens this cycle
//   done_o            - this cycle performs the final iteration; results valid next cycle
//   quotient_o/remainder_o - unsigned results
module wired_mdu_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        kill_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    logic        busy_q;
    logic [4:0]  count_q;
    logic [32:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dsr_q;
    logic [33:0] trial;

    // Shift the next dividend bit into the partial remainder and try subtracting.
    assign trial       = {rem_q, quo_q[31]} - {2'b00, dsr_q};
    assign busy_o      = busy_q;
    assign done_o      = busy_q && (count_q == 5'd31);
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
        end else if (kill_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            busy_q <= 1'b1;
        end else if (done_o) begin
            busy_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start_i) begin
            count_q <= 5'd0;
            rem_q   <= 33'd0;
            quo_q   <= dividend_i;
            dsr_q   <= divisor_i;
        end else if (busy_q) begin
            count_q <= count_q + 5'd1;
            if (!trial[33]) begin
                rem_q <= trial[32:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= {rem_q[31:0], quo_q[31]};
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/wired_mdu.sv
// Multiply/divide unit: one operation in flight, valid/ready on both sides.
// MUL/MULH complete in two cycles; DIV/MOD run the iterative divider on
// operand magnitudes and fix up signs afterwards.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid_i/req_ready_o  - request handshake from the issue queue
//   req_i                    - op, r0, r1, wid
//   resp_valid_o/resp_ready_i - result handshake toward the CDB FIFO
//   resp_o                   - wid, result
//   flush_i                  - discard the in-flight operation
module wired_mdu
    import wired0_defines::*;
#(
    parameter int unsigned DIV_EARLY_OUT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  iq_mdu_req_t  req_i,
    output logic         resp_valid_o,
    input  logic         resp_ready_i,
    output iq_mdu_resp_t resp_o,
    input  logic         flush_i
);

    mdu_state_e state_q, state_d;

    logic [1:0]  op_q;
    logic [31:0] r0_q;
    logic [31:0] r1_q;
    rob_rid_t    wid_q;
    logic [31:0] result_q;

    logic        accept;
    logic        is_div_req;
    logic        early_req;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic signed [63:0] product;
    logic [31:0] q_signed;
    logic [31:0] r_signed;
    logic [31:0] fix_result;

    assign req_ready_o  = (state_q == StIdle);
    assign accept       = req_valid_i && req_ready_o && !flush_i;
    assign is_div_req   = req_i.op[1];
    assign early_req    = (DIV_EARLY_OUT != 0) && div_special(req_i.r0, req_i.r1);
    assign div_start    = accept && is_div_req && !early_req;

    assign resp_valid_o  = (state_q == StDone);
    assign resp_o.wid    = wid_q;
    assign resp_o.result = result_q;

    wired_mdu_div u_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_start),
        .kill_i      (flush_i),
        .dividend_i  (abs32(req_i.r0)),
        .divisor_i   (abs32(req_i.r1)),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!is_div_req)    state_d = StMul;
                    else if (early_req) state_d = StFix;
                    else                state_d = StDiv;
                end
            end
            StMul: state_d = StDone;
            StDiv: begin
                if (div_done)       state_d = StFix;
                else if (!div_busy) state_d = StIdle; // divider lost; never expected
            end
            StFix: state_d = StDone;
            StDone: begin
                if (resp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Flush wins over everything, including a same-cycle handshake.
        if (flush_i) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    assign product = $signed({{32{r0_q[31]}}, r0_q}) * $signed({{32{r1_q[31]}}, r1_q});

    // Sign correction: quotient negative when operand signs differ,
    // remainder takes the dividend's sign.
    always_comb begin
        q_signed = (r0_q[31] ^ r1_q[31]) ? -div_quo : div_quo;
        r_signed = r0_q[31] ? -div_rem : div_rem;
        if (r1_q == 32'd0) begin
            fix_result = (op_q == MDU_DIV) ? 32'hFFFF_FFFF : r0_q;
        end else if (div_special(r0_q, r1_q)) begin
            fix_result = (op_q == MDU_DIV) ? 32'h8000_0000 : 32'd0;
        end else begin
            fix_result = (op_q == MDU_DIV) ? q_signed : r_signed;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= req_i.op;
            r0_q  <= req_i.r0;
            r1_q  <= req_i.r1;
            wid_q <= req_i.wid;
        end
        if (state_q == StMul) begin
            result_q <= (op_q == MDU_MUL) ? product[31:0] : product[63:32];
        end else if (state_q == StFix) begin
            result_q <= fix_result;
        end
    end

endmodule

// File: tb/tb_wired_mdu.sv
module tb_wired_mdu;
    import wired0_defines::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    iq_mdu_req_t  req = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    iq_mdu_resp_t resp;
    logic         flush = 1'b0;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    wired_mdu #(.DIV_EARLY_OUT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_i        (req),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_o       (resp),
        .flush_i      (flush)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the op definitions.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        case (op)
            MDU_MUL:  return p[31:0];
            MDU_MULH: return p[63:32];
            MDU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            default: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!op[1]) return 2;
        if (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
        return 34;
    endfunction

    // Transaction-level model: one op in flight, result due m_lat cycles after acceptance.
    bit          m_busy = 1'b0;
    int          m_age = 0;
    int          m_lat = 0;
    logic [31:0] m_res = '0;
    logic [5:0]  m_wid = '0;

    always @(posedge clk) begin
        if (rst || flush) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_age >= m_lat && resp_ready) m_busy = 1'b0;
            else m_age++;
        end else if (req_valid) begin
            m_busy = 1'b1;
            m_age  = 1;
            m_lat  = ref_lat(req.op, req.r0, req.r1);
            m_res  = ref_result(req.op, req.r0, req.r1);
            m_wid  = req.wid;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mon_ready", 64'(req_ready), 64'(!m_busy));
            chk("mon_valid", 64'(resp_valid), 64'(m_busy && m_age >= m_lat));
            if (m_busy && m_age >= m_lat) begin
                chk("mon_result", 64'(resp.result), 64'(m_res));
                chk("mon_wid", 64'(resp.wid), 64'(m_wid));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] wid);
        @(negedge clk);
        req.op    = op;
        req.r0    = a;
        req.r1    = b;
        req.wid   = wid;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Returns the cycle index (acceptance = 0) at which resp_valid is first seen.
    task automatic wait_valid(output int cyc, output bit got);
        cyc = 1;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            cyc++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] wid,
                          input logic [31:0] exp_res, input int exp_lat, input int hold);
        int cyc;
        bit got;
        @(negedge clk);
        chk({name, "_ready_before"}, 64'(req_ready), 64'd1);
        issue(op, a, b, wid);
        wait_valid(cyc, got);
        chk({name, "_resp_seen"}, 64'(got), 64'd1);
        if (!got) return;
        chk({name, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({name, "_result"}, 64'(resp.result), 64'(exp_res));
        chk({name, "_wid"}, 64'(resp.wid), 64'(wid));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, "_hold_result"}, 64'(resp.result), 64'(exp_res));
            chk({name, "_hold_ready"}, 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk({name, "_ready_after"}, 64'(req_ready), 64'd1);
        chk({name, "_valid_after"}, 64'(resp_valid), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 9))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit got;

        // Reset
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("reset_ready", 64'(req_ready), 64'd1);
        chk("reset_valid", 64'(resp_valid), 64'd0);
        rst = 1'b0;

        // Pin the reference model on hand-computed values
        chk("model_div_m7_2", 64'(ref_result(MDU_DIV, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFD);
        chk("model_mod_m7_2", 64'(ref_result(MDU_MOD, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFF);
        chk("model_mulh", 64'(ref_result(MDU_MULH, 32'h0001_0000, 32'h0001_0000)), 64'd1);
        chk("model_mod_7_m2", 64'(ref_result(MDU_MOD, 32'd7, 32'hFFFF_FFFE)), 64'd1);

        // Directed cases with literal expectations
        run_op("mul", MDU_MUL, 32'h0001_0000, 32'h0001_0000, 6'd5, 32'h0000_0000, 2, 0);
        run_op("mulh", MDU_MULH, 32'h0001_0000, 32'h0001_0000, 6'd6, 32'h0000_0001, 2, 0);
        run_op("mulh_neg", MDU_MULH, 32'hFFFF_FFFF, 32'd3, 6'd7, 32'hFFFF_FFFF, 2, 0);
        run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 6'd8, 32'hFFFF_FFFD, 34, 0);
        run_op("mod_m7_2", MDU_MOD, 32'hFFFF_FFF9, 32'd2, 6'd9, 32'hFFFF_FFFF, 34, 0);
        run_op("div_5_0", MDU_DIV, 32'd5, 32'd0, 6'd10, 32'hFFFF_FFFF, 2, 0);
        run_op("mod_5_0", MDU_MOD, 32'd5, 32'd0, 6'd11, 32'd5, 2, 0);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12, 32'h8000_0000, 2, 0);
        run_op("mod_ovf", MDU_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 6'd13, 32'd0, 2, 0);
        run_op("div_stall", MDU_DIV, 32'd100, 32'd7, 6'd14, 32'd14, 34, 10);

        // Flush at cycle 10 of a divide
        issue(MDU_DIV, 32'd1000, 32'd3, 6'd20);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("flush_no_resp", 64'(resp_valid), 64'd0);
        end
        run_op("mul_after_flush", MDU_MUL, 32'd12345, 32'd1000, 6'd21, 32'd12345000, 2, 0);

        // Request offered during a flush while idle is ignored
        @(negedge clk);
        req.op = MDU_MUL; req.r0 = 32'd3; req.r1 = 32'd4; req.wid = 6'd22;
        req_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_ignored", 64'(req_ready), 64'd1);

        // Reset while in the multiply state
        issue(MDU_MUL, 32'd6, 32'd7, 6'd23);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_mid_no_resp", 64'(resp_valid), 64'd0);
        end

        // Flush coinciding with the response handshake
        issue(MDU_MUL, 32'd9, 32'd9, 6'd24);
        wait_valid(cyc, got);
        chk("flush_hs_seen", 64'(got), 64'd1);
        chk("flush_hs_result", 64'(resp.result), 64'd81);
        resp_ready = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_hs_ready", 64'(req_ready), 64'd1);
        chk("flush_hs_valid", 64'(resp_valid), 64'd0);

        // Randomized operations, checked against the reference arithmetic
        for (int n = 0; n < 60; n++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            logic [5:0]  wid;
            op  = 2'($urandom_range(0, 3));
            a   = pick_operand();
            b   = pick_operand();
            wid = 6'($urandom);
            run_op("rand", op, a, b, wid, ref_result(op, a, b), ref_lat(op, a, b),
                   int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wired_mdu.md
WIRED_MDU -- requirements
Module: wired_mdu

Interface
REQ-001 The block SHALL have one parameter: DIV_EARLY_OUT, default 1, meaning that divide-by-zero and INT_MIN/-1 bypass the iteration loop.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req_valid_i, input, 1 bit: the issue queue offers an operation.
REQ-005 The block SHALL have port req_ready_o, output, 1 bit: the MDU accepts an operation this cycle.
REQ-006 The block SHALL have port req_i, input, $bits(iq_mdu_req_t): fields op[1:0], r0, r1 (32 bits each) and wid (rob_rid_t).
REQ-007 The block SHALL have port resp_valid_o, output, 1 bit: a result is presented.
REQ-008 The block SHALL have port resp_ready_i, input, 1 bit: the CDB-side FIFO accepts the result.
REQ-009 The block SHALL have port resp_o, output, $bits(iq_mdu_resp_t): fields wid and result[31:0].
REQ-010 The block SHALL have port flush_i, input, 1 bit: backend flush; the in-flight operation is discarded.

Function
REQ-011 Op encoding SHALL be as follows.
- 00 = MUL: low 32 bits of r0*r1.
- 01 = MULH: high 32 bits of the signed 64-bit product.
- 10 = DIV: signed quotient r0/r1, truncated toward zero.
- 11 = MOD: signed remainder; its sign follows r0.
REQ-012 The FSM SHALL have states IDLE, MUL, DIV, FIX and DONE; req_ready_o SHALL be 1 only in IDLE (one operation in flight, no overlap).
REQ-013 Acceptance SHALL occur when req_valid_i && req_ready_o in cycle 0; op, operands and wid SHALL be registered in that same edge.
REQ-014 MUL/MULH path: IDLE->MUL at cycle 0, MUL->DONE after 1 cycle, so resp_valid_o=1 from cycle 2.
REQ-015 DIV/MOD path: IDLE->DIV; 32 radix-2 restoring iterations on absolute values in cycles 1..32; FIX (sign correction) in cycle 33; DONE with resp_valid_o=1 from cycle 34.
REQ-016 Divide by zero SHALL produce quotient 0xFFFFFFFF and remainder = r0.
REQ-017 r0=0x80000000 with r1=0xFFFFFFFF SHALL produce quotient 0x80000000 and remainder 0.
REQ-018 With DIV_EARLY_OUT=1, the cases in REQ-016 and REQ-017 SHALL go IDLE->FIX->DONE, so resp_valid_o=1 from cycle 2.
REQ-019 In DONE, resp_o SHALL be held stable while resp_valid_o && !resp_ready_i; on handshake the FSM SHALL return to IDLE, and req_ready_o=1 in the following cycle.
REQ-020 resp_o.wid SHALL equal the wid accepted at cycle 0 for the same operation.
REQ-021 flush_i=1 in any cycle SHALL force IDLE at the next edge and drop any pending result; req_valid_i is ignored in a flush cycle.
REQ-022 Flush and resp handshake in the same cycle SHALL count as consumed (no duplicate, no stall).
REQ-023 All arithmetic SHALL be 32-bit two's complement; the multiply product is 64-bit signed; the divider remainder register is 33 bits.

Reset
REQ-024 On rst=1 at a clock edge: state=IDLE, resp_valid_o=0, req_ready_o=1 after the edge; datapath registers need no reset.
REQ-025 rst asserted mid-operation SHALL abort the operation, with no resp_valid_o afterwards.

Structure
REQ-026 iq_mdu_req_t, iq_mdu_resp_t and the op localparams (MDU_MUL, MDU_MULH, MDU_DIV, MDU_MOD) SHALL live in the shared wired0_defines package.
REQ-027 The iterative divider SHALL be a sub-module wired_mdu_div with start/busy/done, dividend, divisor, quotient and remainder; wired_mdu owns sign handling and the FSM.

Verification
REQ-028 MUL 0x00010000 * 0x00010000, wid=5 -> resp at cycle 2, result=0x00000000, wid=5; MULH gives 0x00000001.
REQ-029 DIV -7/2 -> resp at cycle 34, result=0xFFFFFFFD; MOD -7/2 -> result=0xFFFFFFFF.
REQ-030 DIV 5/0 -> 0xFFFFFFFF at cycle 2; MOD 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-031 DIV issued, resp_ready_i=0 for 10 cycles after resp_valid_o -> resp_o stable and req_ready_o=0 throughout; handshake -> req_ready_o=1 next cycle.
REQ-032 flush_i at cycle 10 of a DIV -> IDLE next cycle, no resp_valid_o; a new MUL accepted afterwards returns correct result at cycle 2.
REQ-033 rst during MUL state -> resp_valid_o stays 0, req_ready_o=1 after the reset edge.
